secc_array_multiplier: RTL and testbench



---
 rtl/secc_array_multiplier.sv | 142 ++++++++++++++
 tb/tb_secc_array_multiplier.sv | 122 ++++++++++++
 2 files changed

// File: rtl/secc_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : secc_array_multiplier
// Purpose  : 4x4 unsigned AND/full-adder array multiplier.
//            It uses the Tiny Tapeout pin interface and has a registered product.
//            Optional macro ARRAY_MULT_PIPE_EN adds a pipeline stage after
//            adder row 1, which gives a latency of 2 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module secc_array_multiplier #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int STW = 3 * N;

  logic [N-1:0]   w_a;
  logic [N-1:0]   w_b;
  logic [N-1:0]   w_pp0;
  logic [STW-1:0] w_stage1;
  logic [STW-1:0] w_stage2;
  logic [N-3:0]   w_b_hi_s2;
  logic [N-1:0]   w_a_s2;
  logic [N-1:0]   w_run_s2;
  logic [1:0]     w_lo_s2;
  logic [2*N-1:0] w_product;
  logic [2*N-1:0] product_d;
  logic [2*N-1:0] product_q;
  logic           w_unused;

  assign w_a   = ui_in[N-1:0];
  assign w_b   = ui_in[2*N-1:N];
  assign w_pp0 = w_a & {N{w_b[0]}};

  // Row i adds pp[i][*] to the running sum. Bit 0 of the result is a
  // finished product bit. The rest, with the carry-out, feed the next row.
  for (genvar i = 1; i < N; i++) begin : g_row
    logic [N-1:0] w_in;
    logic [N-1:0] w_a_op;
    logic         w_b_op;
    logic [N-1:0] w_out;
    logic         w_pbit;

    if (i == 1) begin : g_src_first
      assign w_in   = {1'b0, w_pp0[N-1:1]};
      assign w_a_op = w_a;
      assign w_b_op = w_b[1];
    end else if (i == 2) begin : g_src_stage
      assign w_in   = w_run_s2;
      assign w_a_op = w_a_s2;
      assign w_b_op = w_b_hi_s2[0];
    end else begin : g_src_chain
      assign w_in   = g_row[i-1].w_out;
      assign w_a_op = w_a_s2;
      assign w_b_op = w_b_hi_s2[i-2];
    end

    for (genvar j = 0; j < N; j++) begin : g_col
      logic w_ci;
      logic w_pp;
      logic w_s;
      logic w_co;

      if (j == 0) begin : g_ci_zero
        assign w_ci = 1'b0;
      end else begin : g_ci_chain
        assign w_ci = g_col[j-1].w_co;
      end

      assign w_pp = w_a_op[j] & w_b_op;
      assign w_s  = w_in[j] ^ w_pp ^ w_ci;
      assign w_co = (w_in[j] & w_pp) | (w_in[j] & w_ci) | (w_pp & w_ci);
    end

    assign w_pbit = g_col[0].w_s;
    for (genvar j = 1; j < N; j++) begin : g_out
      assign w_out[j-1] = g_col[j].w_s;
    end
    assign w_out[N-1] = g_col[N-1].w_co;
  end

  // Row 1 leaves these values for the remaining rows: {B[3:2], A, sum, P[1:0]}.
  assign w_stage1 = {w_b[N-1:2], w_a, g_row[1].w_out, g_row[1].w_pbit, w_pp0[0]};

`ifdef ARRAY_MULT_PIPE_EN
  logic [STW-1:0] stage_d;
  logic [STW-1:0] stage_q;

  always_comb begin
    stage_d = stage_q;
    if (ena) begin
      stage_d = w_stage1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign w_stage2 = stage_q;
`else
  assign w_stage2 = w_stage1;
`endif

  assign {w_b_hi_s2, w_a_s2, w_run_s2, w_lo_s2} = w_stage2;

  assign w_product = {g_row[N-1].w_out, g_row[N-1].w_pbit, g_row[2].w_pbit, w_lo_s2};

  always_comb begin
    product_d = product_q;
    if (ena) begin
      product_d = w_product;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      product_q <= '0;
    end else begin
      product_q <= product_d;
    end
  end

  assign uo_out   = product_q;
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign w_unused = ^uio_in;

endmodule
`default_nettype wire

// File: tb/tb_secc_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_secc_array_multiplier
// Purpose  : Scoreboard bench for secc_array_multiplier (both latency builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_secc_array_multiplier;

`ifdef ARRAY_MULT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int         n_checks;
  int         n_fail;
  logic [7:0] sb_q[$];
  logic [7:0] exp_out;

  secc_array_multiplier #(.N(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [7:0] u);
    int p;
    p = int'(u[3:0]) * int'(u[7:4]);
    return p[7:0];
  endfunction

  // The bench drives garbage first and the real operands later, so only the
  // value present at the clock edge should count.
  task automatic step(input logic r, input logic e, input logic [7:0] u, input string tag);
    rst    = r;
    ena    = e;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    #2;
    ui_in  = u;
    uio_in = 8'($urandom);
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      for (int k = 0; k < LAT - 1; k++) sb_q.push_back(8'h00);
      exp_out = 8'h00;
    end else if (e) begin
      sb_q.push_back(ref_prod(u));
      exp_out = sb_q.pop_front();
    end
    #1;
    chk(tag, uo_out, exp_out);
    chk({tag, "_uio_out"}, uio_out, 8'h00);
    chk({tag, "_uio_oe"}, uio_oe, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_out  = 8'h00;
    rst      = 1'b1;
    ena      = 1'b1;
    ui_in    = 8'hFF;
    uio_in   = 8'h00;
    @(negedge clk);

    step(1'b1, 1'b1, 8'hFF, "reset");
    step(1'b1, 1'b1, 8'hFF, "reset");

    step(1'b0, 1'b1, 8'h53, "a3_b5");
    step(1'b0, 1'b1, 8'hFF, "a15_b15");
    step(1'b0, 1'b1, 8'h0F, "a15_b0");
    step(1'b0, 1'b1, 8'h21, "b2b_21");
    step(1'b0, 1'b1, 8'h32, "b2b_32");
    step(1'b0, 1'b1, 8'h43, "b2b_43");
    step(1'b0, 1'b1, 8'h77, "load_77");
    for (int k = 0; k < LAT - 1; k++) step(1'b0, 1'b1, 8'h77, "load_77");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h11, "hold");
    step(1'b0, 1'b1, 8'h11, "resume");
    for (int k = 0; k < LAT - 1; k++) step(1'b0, 1'b1, 8'h11, "resume");

    for (int v = 0; v < 256; v++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom), "gap");
      if (v == 100 || v == 200) begin
        step(1'b1, 1'($urandom), 8'($urandom), "mid_rst");
        step(1'b0, 1'b1, 8'hFF, "post_rst");
      end
      step(1'b0, 1'b1, 8'(v), "sweep");
    end
    for (int k = 0; k < LAT; k++) step(1'b0, 1'b1, 8'hE7, "drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
